// File: rtl/banked_mem_responder.sv
// banked_mem_responder
//   Four-bank interleaved 16-bit word memory serving the cache controller's
//   memory-side port. Each bank is occupied for four cycles after it accepts a
//   request. A well-formed request to a busy bank stalls. A malformed request
//   raises err and is dropped. Reads return data exactly two cycles after they
//   are accepted.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset
//   addr       byte address: bank = addr[2:1], word index = addr[BANK_AW+2:3]
//   data_in    write data, sampled in the accept cycle
//   wr, rd     request strobes (exactly one may be set for a valid request)
//   data_out   read data while data_valid=1, otherwise 16'h0000
//   data_valid data_out carries read data this cycle
//   stall      well-formed request hit a busy bank and was not accepted
//   busy       per-bank occupancy, derived from registered counters
//   err        malformed request (odd address or rd&wr), not accepted
module banked_mem_responder #(
   parameter int BANK_AW = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        wr,
   input  logic        rd,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        stall,
   output logic [3:0]  busy,
   output logic        err
);

   localparam int DEPTH = 4 << BANK_AW;

   logic [1:0]         bank;
   logic [BANK_AW-1:0] idx;
   logic               well_formed;
   logic               accept;

   // Address bits above the word index alias onto the same word.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[15:BANK_AW+3];

   assign bank = addr[2:1];
   assign idx  = addr[BANK_AW+2:3];

   // Well-formed: exactly one strobe and a word-aligned address.
   assign well_formed = (rd ^ wr) & ~addr[0];
   assign err         = (rd | wr) & (addr[0] | (rd & wr));
   assign stall       = well_formed & busy[bank];
   assign accept      = well_formed & ~busy[bank];

   // Per-bank occupancy counters: loaded with 3 on accept, so the bank reads
   // busy for the three following cycles and is free again on the fourth.
   logic [1:0] cnt [4];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      busy = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         busy[b] = (cnt[b] != 2'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            cnt[b] <= 2'd0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (accept && (bank == b[1:0])) begin
               cnt[b] <= 2'd3;
            end else if (cnt[b] != 2'd0) begin
               cnt[b] <= cnt[b] - 2'd1;
            end
         end
      end
   end

   // Storage: bank-major flat array, location = {bank, idx}.
   logic [15:0] mem [DEPTH];

   // NOTE: the array has no reset; contents survive rst and only writes change them.
   always_ff @(posedge clk) begin
      if (!rst && accept && wr) begin
         mem[{bank, idx}] <= data_in;
      end
   end

   // Two-stage read pipeline: stage 1 latches the location, stage 2 reads the
   // array and registers the result, giving data_valid two cycles after accept.
   logic                 s1_valid;
   logic [BANK_AW+1:0]   s1_loc;
   logic                 s2_valid;
   logic [15:0]          s2_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_loc   <= '0;
         s2_valid <= 1'b0;
         s2_data  <= 16'h0000;
      end else begin
         s1_valid <= accept & rd;
         s1_loc   <= {bank, idx};
         s2_valid <= s1_valid;
         // Zero when idle so data_out reads 0 outside data_valid.
         s2_data  <= s1_valid ? mem[s1_loc] : 16'h0000;
      end
   end

   assign data_valid = s2_valid;
   assign data_out   = s2_data;

endmodule

// File: doc/banked_mem_responder.md
# banked_mem_responder

Four-bank interleaved word memory that services read/write requests issued by the direct-mapped cache controller's memory-side port. Each bank is occupied for four cycles after accepting a request. Conflicting requests are stalled, and malformed requests are flagged with an error. Reads return data with a fixed two-cycle latency, so the controller can overlap accesses to different banks.

## Interface
- BANK_AW, 6, word-address width per bank; each bank holds 2^BANK_AW 16-bit words
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-high
- addr  input  16  byte address of the request
- data_in  input  16  write data, sampled in the accept cycle
- wr  input  1  write request
- rd  input  1  read request
- data_out  output  16  read data; valid only while data_valid=1, otherwise 16'h0000
- data_valid  output  1  data_out holds read data this cycle
- stall  output  1  combinational; well-formed request targets a busy bank and is not accepted
- busy  output  4  registered; busy[b]=1 while bank b is occupied
- err  output  1  combinational; malformed request, not accepted

## Operation
- Bank select is addr[2:1]; word index is addr[BANK_AW+2:3]; addresses above that alias.
- Malformed request: (rd|wr) & (addr[0] | (rd&wr)).
  - err=1 and stall=0 in the same cycle.
  - No state change.
- stall = (rd^wr) & ~addr[0] & busy[bank]. err and stall are never both high.
- Accept condition: (rd^wr) & ~addr[0] & ~busy[bank]. "Accept cycle N" below means the cycle in which this holds.
- Per-bank 2-bit occupancy counter cnt_b; busy[b] = (cnt_b != 0).
  - On accept, cnt_b <= 3.
  - Otherwise a nonzero counter decrements by 1 each cycle.
- Write accepted at N:
  - bank[b][idx] <= data_in at the end of N.
  - No read-pipeline activity.
- Read accepted at N:
  - Stage 1 captures {bank, idx} at the end of N.
  - Stage 2 reads the array and registers data_out at the end of N+1.
  - data_valid=1 during N+2 only.
- Independent banks may accept on consecutive cycles. The pipeline holds one read per stage, so back-to-back reads to different banks produce back-to-back data_valid cycles in issue order.
- A same-bank read-after-write hazard cannot occur, because of 4-cycle occupancy.
- Requests to different banks are never stalled by each other.

## Timing
- Reset (rst=1 at a rising edge), in the following cycle:
  - busy=4'b0000, data_valid=0, data_out=16'h0000.
  - Pipeline stages are cleared; in-flight reads are discarded and never return.
  - Array contents are unchanged by reset.
- stall and err depend on inputs that cycle plus registered busy; they are undefined while rst is asserted and are ignored by the requester then.
- Bank occupancy: accept at N gives busy[b]=1 during N+1..N+3; the bank can accept again at N+4.
- Read latency is exactly 2 cycles, accept to data_valid.
- Write is visible to a read accepted at N+4 or later, with data at N+6.
- The requester holds addr/rd/wr/data_in stable while stall=1. The responder keeps no record of stalled or errored requests.
- Simultaneous accept on bank b while cnt_b is decrementing cannot happen, because accept requires busy[b]=0.

## Test plan
- Reset: assert rst one cycle mid-read (read accepted at N, rst at N+1) -> data_valid=0 at N+2, busy=0000 at N+2.
- Write/read one word:
  - wr addr=16'h0010, data_in=16'hBEEF at N -> busy=0001 during N+1..N+3.
  - rd addr=16'h0010 at N+4 -> data_valid=1, data_out=16'hBEEF at N+6.
- Bank conflict:
  - rd addr=16'h0002 at N -> stall=1 for a rd to addr=16'h000A at N+1..N+3.
  - That rd is accepted at N+4; busy=0010.
- Interleaved reads after preloading banks 0..3 at addresses 0,2,4,6 with 1,2,3,4:
  - Reads issued on four consecutive cycles N..N+3 -> no stall.
  - data_out=1,2,3,4 on N+2..N+5, data_valid continuous.
- Errors:
  - rd addr=16'h0003 -> err=1, stall=0, busy unchanged, no data_valid later.
  - rd=wr=1 addr=16'h0004 -> err=1, memory at 16'h0004 unchanged.
- Aliasing (BANK_AW=6): wr 16'h0200 data 16'h1234, then rd 16'h0000 -> data_out=16'h1234.
